// File: rtl/sfr_pkg.sv
// Shared definitions for the SFR bank: register address map, STATUS bit
// positions and the ID register constant.
package sfr_pkg;

    typedef enum logic [7:0] {
        ADDR_ID         = 8'd0,
        ADDR_TMR_L      = 8'd1,
        ADDR_TMR_H      = 8'd2,
        ADDR_PRESC      = 8'd3,
        ADDR_STATUS     = 8'd4,
        ADDR_IRQ_EN     = 8'd5,
        ADDR_PWM_PERIOD = 8'd6,
        ADDR_PWM_DT     = 8'd7,
        ADDR_PWM_EN     = 8'd8,
        ADDR_ENC        = 8'd9,
        ADDR_SOUT       = 8'd10,
        ADDR_LEVEL      = 8'd11,
        ADDR_DUTY0      = 8'd16
    } sfr_addr_e;

    localparam int ST_TOV      = 0;
    localparam int ST_PWM_WRAP = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_TXE      = 3;

    localparam logic [7:0] ID_BASE = 8'hB0;

    function automatic logic [7:0] sfr_id(input int unsigned num_pwm);
        logic [31:0] n;
        n = num_pwm;
        return ID_BASE | n[7:0];
    endfunction

endpackage

// File: rtl/sfr_bank_if.sv
// Register bus between a host and the SFR bank: address, write strobe/data,
// read strobe and combinational read data.
interface sfr_bank_if;
    logic [7:0] addr;
    logic [7:0] write_val;
    logic       write_valid;
    logic       read_valid;
    logic [7:0] read_val;

    modport master (output addr, write_val, write_valid, read_valid, input read_val);
    modport slave  (input addr, write_val, write_valid, read_valid, output read_val);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an occupancy count.
// A push into a full FIFO is accepted only when a pop frees an entry in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign valid     = (level_r != (PW+1)'(0));
    assign full      = (level_r == (PW+1)'(DEPTH));
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && valid;
    assign head      = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Pointer and occupancy bookkeeping; reset discards any stored bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            level_r  <= (PW+1)'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            level_r <= level_r + (PW+1)'(push_ok_s) - (PW+1)'(pop_ok_s);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/sfr_bank.sv
// Special-function register bank: prescaled 16-bit timer, PWM reference
// generator with shadowed duties, serial TX FIFO and W1C status/irq.
module sfr_bank #(
    parameter int NUM_PWM    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESC_RST  = 99
) (
    input  logic               clk,
    input  logic               rst,
    sfr_bank_if.slave          bus,
    input  logic [7:0]         enc_count,
    output logic [NUM_PWM-1:0] pwm_raw,
    output logic [7:0]         pwm_dead_time,
    output logic               pwm_sync,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               irq
);
    import sfr_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         presc_r, presc_cnt_r, snap_r, pwm_period_r, pwm_dt_r;
    logic [7:0]         irq_en_r, pwm_cnt_r;
    logic [15:0]        tmr_r;
    logic [3:0]         status_r, status_set_s, status_clr_s;
    logic [NUM_PWM-1:0] pwm_en_r;
    logic [7:0]         duty_shadow_r [NUM_PWM];
    logic [7:0]         duty_active_r [NUM_PWM];
    logic               pwm_sync_r, tick_s, pwm_wrap_s, pop_s, sout_wr_s, fifo_full_s;
    logic [LW-1:0]      fifo_level_s;
    logic [7:0]         duty_rd_s, read_mux_s;

    assign tick_s     = (presc_cnt_r == presc_r);
    assign pwm_wrap_s = tick_s && (pwm_cnt_r >= pwm_period_r);
    assign sout_wr_s  = bus.write_valid && (bus.addr == ADDR_SOUT);
    assign pop_s      = tx_valid && tx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sout_wr_s),
        .push_data (bus.write_val),
        .pop       (pop_s),
        .head      (tx_data),
        .valid     (tx_valid),
        .full      (fifo_full_s),
        .level     (fifo_level_s)
    );

    // Prescaler, timer and the TMR_H snapshot taken when TMR_L is read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r     <= 8'(PRESC_RST);
            presc_cnt_r <= 8'h00;
            tmr_r       <= 16'h0000;
            snap_r      <= 8'h00;
        end else begin
            if (bus.write_valid && bus.addr == ADDR_PRESC) begin
                presc_r     <= bus.write_val;
                presc_cnt_r <= 8'h00;
            end else if (tick_s) begin
                presc_cnt_r <= 8'h00;
            end else begin
                presc_cnt_r <= presc_cnt_r + 8'd1;
            end
            if (tick_s) tmr_r <= tmr_r + 16'd1;
            if (bus.read_valid && bus.addr == ADDR_TMR_L) snap_r <= tmr_r[15:8];
        end
    end

    // Plain read/write configuration registers and duty shadows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_period_r <= 8'hFF;
            pwm_dt_r     <= 8'h00;
            pwm_en_r     <= {NUM_PWM{1'b0}};
            irq_en_r     <= 8'h00;
            for (int i = 0; i < NUM_PWM; i++) duty_shadow_r[i] <= 8'h00;
        end else if (bus.write_valid) begin
            if (bus.addr == ADDR_PWM_PERIOD) pwm_period_r <= bus.write_val;
            if (bus.addr == ADDR_PWM_DT)     pwm_dt_r     <= bus.write_val;
            if (bus.addr == ADDR_PWM_EN)     pwm_en_r     <= bus.write_val[NUM_PWM-1:0];
            if (bus.addr == ADDR_IRQ_EN)     irq_en_r     <= bus.write_val;
            for (int i = 0; i < NUM_PWM; i++) begin
                if (bus.addr == (ADDR_DUTY0 + 8'(i))) duty_shadow_r[i] <= bus.write_val;
            end
        end
    end

    // PWM counter; a counter already past a shrunken period wraps on the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r  <= 8'h00;
            pwm_sync_r <= 1'b0;
            for (int i = 0; i < NUM_PWM; i++) duty_active_r[i] <= 8'h00;
        end else begin
            pwm_sync_r <= pwm_wrap_s;
            if (pwm_wrap_s) begin
                pwm_cnt_r <= 8'h00;
                for (int i = 0; i < NUM_PWM; i++) duty_active_r[i] <= duty_shadow_r[i];
            end else if (tick_s) begin
                pwm_cnt_r <= pwm_cnt_r + 8'd1;
            end
        end
    end

    // Hardware set events and software W1C mask.
    always_comb begin
        status_set_s              = 4'b0000;
        status_set_s[ST_TOV]      = tick_s && (tmr_r == 16'hFFFF);
        status_set_s[ST_PWM_WRAP] = pwm_wrap_s;
        status_set_s[ST_OVF]      = sout_wr_s && fifo_full_s && !pop_s;
        status_set_s[ST_TXE]      = (fifo_level_s == LW'(1)) && pop_s && !sout_wr_s;
        if (bus.write_valid && bus.addr == ADDR_STATUS) begin
            status_clr_s = bus.write_val[3:0];
        end else begin
            status_clr_s = 4'b0000;
        end
    end

    // Status register; a simultaneous set wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_r <= 4'b0000;
        else     status_r <= (status_r & ~status_clr_s) | status_set_s;
    end

    // Per-channel PWM reference compare.
    always_comb begin
        pwm_raw = {NUM_PWM{1'b0}};
        for (int i = 0; i < NUM_PWM; i++) begin
            pwm_raw[i] = pwm_en_r[i] && (pwm_cnt_r < duty_active_r[i]);
        end
    end

    // Duty readback selects the shadow (last written) value.
    always_comb begin
        duty_rd_s = 8'h00;
        for (int i = 0; i < NUM_PWM; i++) begin
            duty_rd_s = duty_rd_s | (duty_shadow_r[i] & {8{bus.addr == (ADDR_DUTY0 + 8'(i))}});
        end
    end

    // Register read multiplexer.
    always_comb begin
        read_mux_s = 8'h00;
        case (bus.addr)
            ADDR_ID:         read_mux_s = sfr_id(NUM_PWM);
            ADDR_TMR_L:      read_mux_s = tmr_r[7:0];
            ADDR_TMR_H:      read_mux_s = snap_r;
            ADDR_PRESC:      read_mux_s = presc_r;
            ADDR_STATUS:     read_mux_s = {4'h0, status_r};
            ADDR_IRQ_EN:     read_mux_s = irq_en_r;
            ADDR_PWM_PERIOD: read_mux_s = pwm_period_r;
            ADDR_PWM_DT:     read_mux_s = pwm_dt_r;
            ADDR_PWM_EN:     read_mux_s = 8'(pwm_en_r);
            ADDR_ENC:        read_mux_s = enc_count;
            ADDR_SOUT:       read_mux_s = 8'h00;
            ADDR_LEVEL:      read_mux_s = 8'(fifo_level_s);
            default:         read_mux_s = duty_rd_s;
        endcase
    end

    assign bus.read_val  = read_mux_s;
    assign pwm_sync      = pwm_sync_r;
    assign pwm_dead_time = pwm_dt_r;
    assign irq           = |(status_r & irq_en_r[3:0]);

endmodule
